seq_comparator: RTL



---
 rtl/seq_comparator.sv | 127 ++++++++++++
 1 files changed

// File: rtl/seq_comparator.sv
// Digit-serial magnitude comparator: scans latched operands MSB-first, DIGIT bits
// per clock, stopping at the first differing digit; equal operands resolve via l/e/g.
module seq_comparator #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  input  logic             l,
  input  logic             e,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             et,
  output logic             gt
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = ~({WIDTH{1'b1}} >> 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             l_reg, g_reg;
  logic [IW-1:0]    idx_reg;
  logic             busy_reg, done_reg, lt_reg, et_reg, gt_reg;

  // With g > l > e priority, e never changes the outcome: equality is the fallback.
  logic unused_cascade_e;
  assign unused_cascade_e = e;

  logic [DIGIT-1:0] a_slice [NSLICE];
  logic [DIGIT-1:0] b_slice [NSLICE];
  logic [DIGIT-1:0] a_cur, b_cur;
  logic             last_slice;

  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign a_slice[gi] = a_reg[WIDTH-1-gi*DIGIT -: DIGIT];
      assign b_slice[gi] = b_reg[WIDTH-1-gi*DIGIT -: DIGIT];
    end
  endgenerate

  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_reg == IW'(i)) begin
        a_cur = a_slice[i];
        b_cur = b_slice[i];
      end
    end
  end

  assign last_slice = (idx_reg == IW'(NSLICE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      l_reg     <= 1'b0;
      g_reg     <= 1'b0;
      idx_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      lt_reg    <= 1'b0;
      et_reg    <= 1'b0;
      gt_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            // Flipping the sign bits maps two's-complement order onto unsigned order.
            a_reg     <= A ^ (signed_mode ? MSB_MASK : '0);
            b_reg     <= B ^ (signed_mode ? MSB_MASK : '0);
            l_reg     <= l;
            g_reg     <= g;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            lt_reg    <= 1'b0;
            et_reg    <= 1'b0;
            gt_reg    <= 1'b0;
            state_reg <= SCAN;
          end
        end
        SCAN: begin
          if (a_cur > b_cur) begin
            gt_reg    <= 1'b1;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (a_cur < b_cur) begin
            lt_reg    <= 1'b1;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (last_slice) begin
            gt_reg    <= g_reg;
            lt_reg    <= l_reg & ~g_reg;
            et_reg    <= ~g_reg & ~l_reg;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign lt   = lt_reg;
  assign et   = et_reg;
  assign gt   = gt_reg;

endmodule
